ap_ctrl_perf_monitor: RTL and testbench



---
 rtl/ap_mon_pkg.sv | 32 +++
 rtl/ap_ctrl_perf_monitor_if.sv | 35 +++
 rtl/ap_ch_monitor.sv | 148 ++++++++++++++
 rtl/ap_ctrl_perf_monitor.sv | 67 ++++++
 tb/tb_ap_ctrl_perf_monitor.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ap_mon_pkg.sv
// ap_mon_pkg: shared types, read-select codes, status bit positions and the saturating increment
package ap_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2
    } state_t;

    localparam int NUM_SEL = 8;
    localparam int SEL_W   = 3;

    localparam logic [SEL_W-1:0] SEL_TXN    = 3'd0;
    localparam logic [SEL_W-1:0] SEL_BUSY   = 3'd1;
    localparam logic [SEL_W-1:0] SEL_LAST   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_MIN    = 3'd3;
    localparam logic [SEL_W-1:0] SEL_MAX    = 3'd4;
    localparam logic [SEL_W-1:0] SEL_READY  = 3'd5;
    localparam logic [SEL_W-1:0] SEL_STALL  = 3'd6;
    localparam logic [SEL_W-1:0] SEL_STATUS = 3'd7;

    localparam int STAT_ERR_BIT  = 2;
    localparam int STAT_WDOG_BIT = 3;

    // Increment v as a w-bit counter that sticks at all-ones instead of wrapping
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
        return (v >= top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/ap_ctrl_perf_monitor_if.sv
// ap_ctrl_perf_monitor_if: monitored ap_ctrl handshakes, read port and status flags
interface ap_ctrl_perf_monitor_if
    import ap_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = $clog2(NUM_CH) + 1;

    logic              finish;
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [SEL_W-1:0]  rd_sel;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] err;
    logic [NUM_CH-1:0] wdog_trip;
    logic              frozen;

    modport master (
        output finish, ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
        input  rd_valid, rd_data, busy, err, wdog_trip, frozen
    );

    modport slave (
        input  finish, ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
        output rd_valid, rd_data, busy, err, wdog_trip, frozen
    );

endinterface

// File: rtl/ap_ch_monitor.sv
// ap_ch_monitor: one ap_ctrl handshake FSM with its statistics; AP_MON_WATCHDOG_EN adds a stall watchdog
module ap_ch_monitor
    import ap_mon_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              hold_i,
    input  logic                              ap_start_i,
    input  logic                              ap_ready_i,
    input  logic                              ap_done_i,
    input  logic                              ap_continue_i,
    output logic                              busy_o,
    output logic                              err_o,
    output logic                              wdog_o,
    output logic [NUM_SEL-1:0][CNT_W-1:0]     stat_o
);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        logic [63:0] w;
        w = sat_inc(64'(v), CNT_W);
        return w[CNT_W-1:0];
    endfunction

    state_t           st_q, st_d;
    logic [CNT_W-1:0] lat_q, lat_d, txn_q, txn_d, bcyc_q, bcyc_d, last_q, last_d;
    logic [CNT_W-1:0] min_q, min_d, max_q, max_d, rdy_q, rdy_d, stall_q, stall_d;
    logic [CNT_W-1:0] rec;
    logic             err_q, err_d;

    // Latency of a finishing transaction includes the done cycle itself
    assign rec = inc(lat_q);

    // Next-state and counter updates; the start cycle counts as a busy cycle
    always_comb begin
        st_d    = st_q;
        lat_d   = lat_q;
        txn_d   = txn_q;
        bcyc_d  = bcyc_q;
        last_d  = last_q;
        min_d   = min_q;
        max_d   = max_q;
        stall_d = stall_q;
        err_d   = err_q;
        rdy_d   = ap_ready_i ? inc(rdy_q) : rdy_q;
        case (st_q)
            ST_IDLE: begin
                err_d = err_q | ap_done_i;
                if (ap_start_i) begin
                    st_d   = ST_BUSY;
                    lat_d  = CNT_W'(1);
                    bcyc_d = inc(bcyc_q);
                end
            end
            ST_BUSY: begin
                bcyc_d = inc(bcyc_q);
                lat_d  = rec;
                if (ap_done_i) begin
                    last_d = rec;
                    min_d  = (rec < min_q) ? rec : min_q;
                    max_d  = (rec > max_q) ? rec : max_q;
                    txn_d  = inc(txn_q);
                    lat_d  = CNT_W'(1);
                    st_d   = !ap_continue_i ? ST_DONE_WAIT : ap_start_i ? ST_BUSY : ST_IDLE;
                end
            end
            ST_DONE_WAIT: begin
                stall_d = inc(stall_q);
                if (ap_continue_i) begin
                    st_d   = ap_start_i ? ST_BUSY : ST_IDLE;
                    lat_d  = CNT_W'(1);
                    bcyc_d = ap_start_i ? inc(bcyc_q) : bcyc_q;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // State and statistics registers; hold freezes everything until reset
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q    <= ST_IDLE;
            lat_q   <= '0;
            txn_q   <= '0;
            bcyc_q  <= '0;
            last_q  <= '0;
            min_q   <= '1;
            max_q   <= '0;
            rdy_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else if (!hold_i) begin
            st_q    <= st_d;
            lat_q   <= lat_d;
            txn_q   <= txn_d;
            bcyc_q  <= bcyc_d;
            last_q  <= last_d;
            min_q   <= min_d;
            max_q   <= max_d;
            rdy_q   <= rdy_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

`ifdef AP_MON_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    logic        trip_q;

    assign wd_d = (st_q == ST_BUSY && !ap_ready_i && !ap_done_i) ? 32'(sat_inc(64'(wd_q), 32)) : '0;

    // Count consecutive ready-less BUSY cycles; trip is sticky until reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q   <= '0;
            trip_q <= 1'b0;
        end else if (!hold_i) begin
            wd_q   <= wd_d;
            trip_q <= trip_q | (wd_d == 32'(WDOG_CYCLES));
        end
    end

    assign wdog_o = trip_q;
`else
    assign wdog_o = 1'b0;
`endif

    assign busy_o = (st_q != ST_IDLE);
    assign err_o  = err_q;

    // Statistic word per read-select code
    always_comb begin
        stat_o                            = '0;
        stat_o[SEL_TXN]                   = txn_q;
        stat_o[SEL_BUSY]                  = bcyc_q;
        stat_o[SEL_LAST]                  = last_q;
        stat_o[SEL_MIN]                   = min_q;
        stat_o[SEL_MAX]                   = max_q;
        stat_o[SEL_READY]                 = rdy_q;
        stat_o[SEL_STALL]                 = stall_q;
        stat_o[SEL_STATUS][1:0]           = st_q;
        stat_o[SEL_STATUS][STAT_ERR_BIT]  = err_q;
        stat_o[SEL_STATUS][STAT_WDOG_BIT] = wdog_o;
    end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: per-channel ap_ctrl statistics with freeze and registered read port; AP_MON_WATCHDOG_EN enables watchdogs
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    ap_ctrl_perf_monitor_if.slave  bus
);

    localparam int CH_W = $clog2(NUM_CH) + 1;

    logic                             frozen_q, rd_valid_q;
    logic [CNT_W-1:0]                 rd_data_q, rd_mux;
    logic [NUM_CH-1:0]                busy_w, err_w, wdog_w;
    logic [NUM_SEL-1:0][CNT_W-1:0]    stat [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ap_ch_monitor #(
            .CNT_W       (CNT_W),
            .WDOG_CYCLES (WDOG_CYCLES)
        ) u_ch (
            .clock         (clock),
            .reset         (reset),
            .hold_i        (frozen_q),
            .ap_start_i    (bus.ap_start[i]),
            .ap_ready_i    (bus.ap_ready[i]),
            .ap_done_i     (bus.ap_done[i]),
            .ap_continue_i (bus.ap_continue[i]),
            .busy_o        (busy_w[i]),
            .err_o         (err_w[i]),
            .wdog_o        (wdog_w[i]),
            .stat_o        (stat[i])
        );
    end

    // Statistic selected by the current read request; unknown channels read as zero
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (bus.rd_ch == CH_W'(c)) rd_mux = stat[c][bus.rd_sel];
    end

    // Freeze flag and registered read port; data holds between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            frozen_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            frozen_q   <= frozen_q | bus.finish;
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_mux;
        end
    end

    assign bus.busy      = busy_w;
    assign bus.err       = err_w;
    assign bus.wdog_trip = wdog_w;
    assign bus.frozen    = frozen_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb_ap_ctrl_perf_monitor: directed handshake sequences plus a table of statistic reads
module tb_ap_ctrl_perf_monitor;
    import ap_mon_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor_if #(.NUM_CH(4), .CNT_W(32)) bus ();
    ap_ctrl_perf_monitor_if #(.NUM_CH(1), .CNT_W(4))  bus2 ();

    ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32), .WDOG_CYCLES(1000000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    ap_ctrl_perf_monitor #(.NUM_CH(1), .CNT_W(4), .WDOG_CYCLES(16)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

`ifdef AP_MON_WATCHDOG_EN
    localparam logic WD_EXP = 1'b1;
`else
    localparam logic WD_EXP = 1'b0;
`endif

    typedef struct {
        int          ch;
        int          sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rd(input int ch, input int sel, input string nm, input logic [31:0] exp);
        bus.rd_en  = 1'b1;
        bus.rd_ch  = 3'(ch);
        bus.rd_sel = 3'(sel);
        tick();
        bus.rd_en = 1'b0;
        check({nm, ".valid"}, 32'(bus.rd_valid), 32'd1);
        check(nm, bus.rd_data, exp);
    endtask

    task automatic rd2(input int ch, input int sel, input string nm, input logic [31:0] exp);
        bus2.rd_en  = 1'b1;
        bus2.rd_ch  = 1'(ch);
        bus2.rd_sel = 3'(sel);
        tick();
        bus2.rd_en = 1'b0;
        check({nm, ".valid"}, 32'(bus2.rd_valid), 32'd1);
        check(nm, 32'(bus2.rd_data), exp);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.finish = 1'b0;  bus.ap_start = '0;  bus.ap_ready = '0;  bus.ap_done = '0;
        bus.ap_continue = '1;  bus.rd_en = 1'b0;  bus.rd_ch = '0;  bus.rd_sel = '0;
        bus2.finish = 1'b0; bus2.ap_start = '0; bus2.ap_ready = '0; bus2.ap_done = '0;
        bus2.ap_continue = '1; bus2.rd_en = 1'b0; bus2.rd_ch = '0; bus2.rd_sel = '0;

        tbl.push_back('{0, SEL_TXN,    32'd1, "ch0.txn"});
        tbl.push_back('{0, SEL_BUSY,   32'd5, "ch0.busy_cycles"});
        tbl.push_back('{0, SEL_LAST,   32'd5, "ch0.last_lat"});
        tbl.push_back('{0, SEL_MIN,    32'd5, "ch0.min_lat"});
        tbl.push_back('{0, SEL_MAX,    32'd5, "ch0.max_lat"});
        tbl.push_back('{0, SEL_READY,  32'd3, "ch0.ready"});
        tbl.push_back('{0, SEL_STALL,  32'd0, "ch0.stall"});
        tbl.push_back('{0, SEL_STATUS, 32'd0, "ch0.status"});
        tbl.push_back('{1, SEL_TXN,    32'd2, "ch1.txn"});
        tbl.push_back('{1, SEL_BUSY,   32'd9, "ch1.busy_cycles"});
        tbl.push_back('{1, SEL_LAST,   32'd7, "ch1.last_lat"});
        tbl.push_back('{1, SEL_MIN,    32'd3, "ch1.min_lat"});
        tbl.push_back('{1, SEL_MAX,    32'd7, "ch1.max_lat"});
        tbl.push_back('{1, SEL_READY,  32'd1, "ch1.ready"});
        tbl.push_back('{1, SEL_STATUS, 32'd0, "ch1.status"});
        tbl.push_back('{2, SEL_TXN,    32'd1, "ch2.txn"});
        tbl.push_back('{2, SEL_BUSY,   32'd3, "ch2.busy_cycles"});
        tbl.push_back('{2, SEL_LAST,   32'd3, "ch2.last_lat"});
        tbl.push_back('{2, SEL_STALL,  32'd4, "ch2.stall"});
        tbl.push_back('{2, SEL_STATUS, 32'd0, "ch2.status"});
        tbl.push_back('{3, SEL_TXN,    32'd1, "ch3.txn"});
        tbl.push_back('{3, SEL_BUSY,   32'd4, "ch3.busy_cycles"});
        tbl.push_back('{3, SEL_LAST,   32'd4, "ch3.last_lat"});
        tbl.push_back('{3, SEL_MIN,    32'd4, "ch3.min_lat"});
        tbl.push_back('{3, SEL_READY,  32'd1, "ch3.ready"});
        tbl.push_back('{3, SEL_STATUS, 32'd4, "ch3.status_err"});
        tbl.push_back('{4, SEL_TXN,    32'd0, "ch4.out_of_range"});
        tbl.push_back('{7, SEL_MAX,    32'd0, "ch7.out_of_range"});

        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.err", 32'(bus.err), 32'd0);
        check("rst.wdog", 32'(bus.wdog_trip), 32'd0);
        check("rst.frozen", 32'(bus.frozen), 32'd0);
        check("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst.rd_data", bus.rd_data, 32'd0);
        rd(0, SEL_MIN, "rst.min_lat", 32'hFFFF_FFFF);
        rd(0, SEL_TXN, "rst.txn", 32'd0);

        bus.ap_start[0] = 1'b1; tick(); bus.ap_start[0] = 1'b0;
        repeat (3) tick();
        check("ch0.busy_mid", 32'(bus.busy[0]), 32'd1);
        bus.ap_done[0] = 1'b1; tick(); bus.ap_done[0] = 1'b0;
        check("ch0.busy_after_done", 32'(bus.busy[0]), 32'd0);

        bus.ap_start[1] = 1'b1; tick(); bus.ap_start[1] = 1'b0;
        tick();
        bus.ap_done[1] = 1'b1; bus.ap_start[1] = 1'b1; tick();
        bus.ap_done[1] = 1'b0; bus.ap_start[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ch1.never_idle", 32'(bus.busy[1]), 32'd1);
            tick();
        end
        bus.ap_done[1] = 1'b1; tick(); bus.ap_done[1] = 1'b0;
        check("ch1.idle_after", 32'(bus.busy[1]), 32'd0);

        bus.ap_start[2] = 1'b1; tick(); bus.ap_start[2] = 1'b0;
        tick();
        bus.ap_done[2] = 1'b1; bus.ap_continue[2] = 1'b0; tick(); bus.ap_done[2] = 1'b0;
        rd(2, SEL_STATUS, "ch2.status_stall", 32'd2);
        tick();
        check("ch2.rd_valid_idle", 32'(bus.rd_valid), 32'd0);
        check("ch2.rd_data_held", bus.rd_data, 32'd2);
        tick();
        check("ch2.busy_in_stall", 32'(bus.busy[2]), 32'd1);
        bus.ap_continue[2] = 1'b1; tick();
        check("ch2.idle_after_stall", 32'(bus.busy[2]), 32'd0);

        bus.ap_done[3] = 1'b1; tick(); bus.ap_done[3] = 1'b0;
        check("ch3.err_idle_done", 32'(bus.err), 32'h8);
        bus.ap_start[3] = 1'b1; tick(); bus.ap_start[3] = 1'b0;
        repeat (2) tick();
        bus.ap_done[3] = 1'b1; tick(); bus.ap_done[3] = 1'b0;
        check("ch3.err_sticky", 32'(bus.err), 32'h8);

        bus.ap_ready[0] = 1'b1; bus.ap_ready[1] = 1'b1; tick();
        bus.ap_ready[1] = 1'b0; repeat (2) tick();
        bus.ap_ready[0] = 1'b0;

        bus.rd_en = 1'b1; bus.rd_ch = 3'd3; bus.rd_sel = SEL_READY; bus.ap_ready[3] = 1'b1;
        tick();
        bus.rd_en = 1'b0; bus.ap_ready[3] = 1'b0;
        check("ch3.read_pre_update", bus.rd_data, 32'd0);

        foreach (tbl[i]) rd(tbl[i].ch, tbl[i].sel, tbl[i].name, tbl[i].exp);

        bus2.ap_start = 1'b1; tick(); bus2.ap_start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) check("wd.before_16", 32'(bus2.wdog_trip), 32'd0);
            if (i == 16) check("wd.at_16", 32'(bus2.wdog_trip), 32'(WD_EXP));
        end
        bus2.ap_done = 1'b1; tick(); bus2.ap_done = 1'b0;
        bus2.ap_ready = 1'b1; repeat (20) tick(); bus2.ap_ready = 1'b0;
        check("wd.sticky", 32'(bus2.wdog_trip), 32'(WD_EXP));
        rd2(0, SEL_LAST, "sat.last_lat", 32'd15);
        rd2(0, SEL_BUSY, "sat.busy_cycles", 32'd15);
        rd2(0, SEL_READY, "sat.ready", 32'd15);
        rd2(0, SEL_TXN, "sat.txn", 32'd1);
        rd2(0, SEL_STATUS, "wd.status", WD_EXP ? 32'd8 : 32'd0);
        rd2(1, SEL_TXN, "n1.out_of_range", 32'd0);

        bus.ap_start[0] = 1'b1; tick(); bus.ap_start[0] = 1'b0;
        tick();
        bus.ap_done[0] = 1'b1; bus.finish = 1'b1; tick();
        bus.ap_done[0] = 1'b0; bus.finish = 1'b0;
        check("frz.frozen", 32'(bus.frozen), 32'd1);
        bus.ap_start = '1; bus.ap_done = '1; bus.ap_ready = '1; bus.ap_continue = '0;
        repeat (5) tick();
        bus.ap_start = '0; bus.ap_done = '0; bus.ap_ready = '0; bus.ap_continue = '1;
        check("frz.frozen_hold", 32'(bus.frozen), 32'd1);
        check("frz.busy", 32'(bus.busy), 32'd0);
        check("frz.err", 32'(bus.err), 32'h8);
        rd(0, SEL_TXN, "frz.ch0.txn", 32'd2);
        rd(0, SEL_LAST, "frz.ch0.last_lat", 32'd3);
        rd(0, SEL_MIN, "frz.ch0.min_lat", 32'd3);
        rd(0, SEL_MAX, "frz.ch0.max_lat", 32'd5);
        rd(0, SEL_BUSY, "frz.ch0.busy_cycles", 32'd8);
        rd(0, SEL_READY, "frz.ch0.ready", 32'd3);
        rd(1, SEL_TXN, "frz.ch1.txn", 32'd2);
        rd(4, SEL_TXN, "frz.ch4.out_of_range", 32'd0);

        reset = 1'b1; tick(); reset = 1'b0; tick();
        check("rst2.frozen", 32'(bus.frozen), 32'd0);
        bus.ap_start[1] = 1'b1; tick(); bus.ap_start[1] = 1'b0;
        tick();
        reset = 1'b1; bus.ap_done[1] = 1'b1; tick();
        reset = 1'b0; bus.ap_done[1] = 1'b0;
        check("rst2.busy", 32'(bus.busy), 32'd0);
        rd(1, SEL_TXN, "rst2.txn", 32'd0);
        rd(1, SEL_MIN, "rst2.min_lat", 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
